// File: rtl/obi_pkg.sv
// obi_pkg: shared OBI request/response struct types
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

// File: rtl/tinyodin_spike_pkg.sv
// tinyodin_spike_pkg: spike word width and clear FSM states
package tinyodin_spike_pkg;
  localparam int SPIKE_W = 32;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/sram_spike.sv
// sram_spike: single-port synchronous spike word array, byte write mask, 1-cycle read
module sram_spike
  import tinyodin_spike_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [AW-1:0]      addr,
  input  logic [SPIKE_W-1:0] wdata,
  output logic [SPIKE_W-1:0] rdata
);
  logic [SPIKE_W-1:0] mem [DEPTH];
  // writes merge enabled bytes; reads leave rdata holding the last word read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/spike_obi_responder.sv
// spike_obi_responder: OBI slave over the spike bitmap SRAM, shared with the filter read path and a bulk clear
module spike_obi_responder
  import tinyodin_spike_pkg::*;
#(
  parameter int  N      = 256,
  parameter int  ADDR_W = $clog2(N) - 3,
  parameter int  DEPTH  = N / 32,
  parameter type req_t  = obi_pkg::obi_req_t,
  parameter type rsp_t  = obi_pkg::obi_resp_t
) (
  input  logic               CLK,
  input  logic               RST,
  input  req_t               tinyODIN_slave_req_i,
  output rsp_t               tinyODIN_slave_resp_o,
  input  logic               filter_en_i,
  input  logic [ADDR_W-1:0]  filter_addr_i,
  output logic [SPIKE_W-1:0] filter_rdata_o,
  output logic               filter_valid_o,
  input  logic               clear_i,
  output logic               clear_busy_o,
  output logic               clear_done_o
);
  localparam int AW = $clog2(DEPTH);
  req_t req;
  state_t state, state_n;
  logic [AW-1:0] clr_cnt, sram_addr;
  logic [ADDR_W-1:0] obi_idx;
  logic idle, last, gnt, obi_ok, flt_ok;
  logic sram_en, sram_we;
  logic [3:0] sram_be;
  logic [SPIKE_W-1:0] sram_wdata, sram_rdata;
  logic rvalid_q, obi_rd_q, flt_valid_q, flt_ok_q;
  logic unused_addr;
  assign req = tinyODIN_slave_req_i;
  assign unused_addr = ^req.addr[1:0];
  assign idle = state == IDLE;
  assign last = clr_cnt == AW'(DEPTH - 1);
  assign obi_idx = req.addr[ADDR_W+1:2];
  assign obi_ok = req.addr[31:ADDR_W+2] == '0 && obi_idx < ADDR_W'(DEPTH);
  assign flt_ok = filter_addr_i < ADDR_W'(DEPTH);
  // a clear request owns the next cycle, so it blocks OBI in its own cycle too
  assign gnt = req.req & ~filter_en_i & ~clear_i & idle;
  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_n;
  end
  // clear word counter, parked at zero while idle
  always_ff @(posedge CLK) begin
    if (RST || idle) clr_cnt <= '0;
    else clr_cnt <= clr_cnt + 1'b1;
  end
  // next state: clear_i only matters when idle
  always_comb begin
    state_n = idle ? (clear_i ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
  end
  // port mux, priority clear > filter > OBI; out-of-range accesses never touch the array
  always_comb begin
    clear_busy_o = !idle;
    clear_done_o = !idle && last;
    sram_en      = !idle || (filter_en_i && flt_ok) || (gnt && obi_ok);
    sram_we      = !idle || (!filter_en_i && req.we);
    sram_be      = (!idle || req.be == 4'b0000) ? 4'hF : req.be;
    sram_addr    = !idle ? clr_cnt : filter_en_i ? filter_addr_i[AW-1:0] : obi_idx[AW-1:0];
    sram_wdata   = !idle ? '0 : req.wdata;
  end
  // response tracking: one rvalid per grant, read data gated so writes and misses return zero
  always_ff @(posedge CLK) begin
    if (RST) begin
      rvalid_q    <= 1'b0;
      obi_rd_q    <= 1'b0;
      flt_valid_q <= 1'b0;
      flt_ok_q    <= 1'b0;
    end else begin
      rvalid_q    <= gnt;
      obi_rd_q    <= gnt & ~req.we & obi_ok;
      flt_valid_q <= filter_en_i & idle;
      flt_ok_q    <= flt_ok;
    end
  end
  assign tinyODIN_slave_resp_o.gnt    = gnt;
  assign tinyODIN_slave_resp_o.rvalid = rvalid_q;
  assign tinyODIN_slave_resp_o.rdata  = obi_rd_q ? sram_rdata : '0;
  assign filter_valid_o = flt_valid_q;
  assign filter_rdata_o = (flt_valid_q && flt_ok_q) ? sram_rdata : '0;
  sram_spike #(.DEPTH(DEPTH)) u_sram (
    .clk   (CLK),
    .en    (sram_en),
    .we    (sram_we),
    .be    (sram_be),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );
endmodule

// File: tb/tb_spike_obi_responder.sv
// tb_spike_obi_responder: scoreboard bench for the spike OBI responder
module tb_spike_obi_responder;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  obi_pkg::obi_req_t req;
  obi_pkg::obi_resp_t rsp;
  logic filter_en = 1'b0;
  logic [4:0] filter_addr = '0;
  logic [31:0] filter_rdata;
  logic filter_valid;
  logic clear = 1'b0;
  logic clear_busy, clear_done;
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic gnt_prev = 1'b0;
  logic rst_prev = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] model[8];

  spike_obi_responder dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .tinyODIN_slave_req_i  (req),
    .tinyODIN_slave_resp_o (rsp),
    .filter_en_i           (filter_en),
    .filter_addr_i         (filter_addr),
    .filter_rdata_o        (filter_rdata),
    .filter_valid_o        (filter_valid),
    .clear_i               (clear),
    .clear_busy_o          (clear_busy),
    .clear_done_o          (clear_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // rvalid must trail every grant by one cycle; read data popped from the scoreboard
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
    end else begin
      check("rvalid", rsp.rvalid, gnt_prev && !rst_prev);
      if (rsp.rvalid && exp_q.size() > 0) check("rdata", rsp.rdata, exp_q.pop_front());
      if (clear_done) done_cnt++;
    end
    gnt_prev = rsp.gnt;
    rst_prev = RST;
  end

  task automatic obi_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp);
    int waits = 0;
    bit ok = 0;
    logic [3:0] bm;
    req.req = 1'b1; req.we = we; req.addr = addr; req.wdata = wdata; req.be = be;
    while (!ok && waits < 20) begin
      @(negedge CLK);
      if (rsp.gnt) begin
        ok = 1;
        exp_q.push_back(we ? 32'h0 : exp);
      end else waits++;
    end
    check("gnt_latency", waits, 0);
    if (ok && we && addr < 32'h20) begin
      bm = (be == 4'b0000) ? 4'hF : be;
      for (int i = 0; i < 4; i++)
        if (bm[i]) model[addr[4:2]][8*i +: 8] = wdata[8*i +: 8];
    end
    @(posedge CLK); #1;
    req.req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req = '0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_gnt", rsp.gnt, 0);
    check("rst_rvalid", rsp.rvalid, 0);
    check("rst_rdata", rsp.rdata, 0);
    check("rst_fvalid", filter_valid, 0);
    check("rst_frdata", filter_rdata, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    @(posedge CLK); #1;

    // full-word legacy write with be=0, then read back
    obi_xfer(1, 32'h00, 32'hFFFE_FFAF, 4'b0000, 0);
    obi_xfer(0, 32'h00, 0, 4'hF, 32'hFFFE_FFAF);
    // byte-enable merge
    obi_xfer(1, 32'h04, 32'h1122_3344, 4'b1111, 0);
    obi_xfer(1, 32'h07, 32'hAABB_CCDD, 4'b0101, 0);
    obi_xfer(0, 32'h04, 0, 4'h0, 32'h11BB_33DD);

    // filter holds off a pending OBI read for three cycles
    req.req = 1'b1; req.we = 1'b0; req.addr = 32'h04; req.be = 4'h0;
    filter_en = 1'b1; filter_addr = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("flt_gnt", rsp.gnt, 0);
      if (i > 0) begin
        check("flt_valid", filter_valid, 1);
        check("flt_rdata", filter_rdata, 32'hFFFE_FFAF);
      end
      @(posedge CLK); #1;
      if (i == 2) filter_en = 1'b0;
    end
    @(negedge CLK);
    check("flt_release_gnt", rsp.gnt, 1);
    if (rsp.gnt) exp_q.push_back(32'h11BB_33DD);
    check("flt_valid_last", filter_valid, 1);
    check("flt_rdata_last", filter_rdata, 32'hFFFE_FFAF);
    @(posedge CLK); #1;
    req.req = 1'b0;
    @(negedge CLK);
    check("flt_valid_off", filter_valid, 0);
    @(posedge CLK); #1;

    // out-of-range accesses: granted, writes dropped, reads zero
    obi_xfer(1, 32'h20, 32'hDEAD_BEEF, 4'hF, 0);
    obi_xfer(0, 32'h20, 0, 4'hF, 32'h0);
    obi_xfer(1, 32'h100, 32'h0BAD_F00D, 4'hF, 0);
    obi_xfer(0, 32'h00, 0, 4'hF, 32'hFFFE_FFAF);

    // back-to-back grants
    req.req = 1'b1; req.we = 1'b0; req.addr = 32'h00;
    @(negedge CLK);
    check("b2b_gnt0", rsp.gnt, 1);
    if (rsp.gnt) exp_q.push_back(model[0]);
    @(posedge CLK); #1;
    req.addr = 32'h04;
    @(negedge CLK);
    check("b2b_gnt1", rsp.gnt, 1);
    if (rsp.gnt) exp_q.push_back(model[1]);
    @(posedge CLK); #1;
    req.req = 1'b0;
    idle_cycles(2);

    // bulk clear with a pending read held throughout
    for (int w = 0; w < 8; w++) obi_xfer(1, w * 4, 32'hFFFF_FFFF, 4'hF, 0);
    done_cnt = 0;
    clear = 1'b1;
    req.req = 1'b1; req.we = 1'b0; req.addr = 32'h08;
    @(negedge CLK);
    check("clr_start_gnt", rsp.gnt, 0);
    check("clr_start_busy", clear_busy, 0);
    @(posedge CLK); #1;
    clear = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      check("clr_busy", clear_busy, 1);
      check("clr_done", clear_done, c == 8);
      check("clr_gnt", rsp.gnt, 0);
      if (c == 5) check("clr_flt_valid", filter_valid, 0);
      @(posedge CLK); #1;
      clear = (c == 2);
      filter_en = (c == 3);
    end
    @(negedge CLK);
    check("clr_end_busy", clear_busy, 0);
    check("clr_end_done", clear_done, 0);
    check("clr_end_gnt", rsp.gnt, 1);
    if (rsp.gnt) exp_q.push_back(32'h0);
    @(posedge CLK); #1;
    req.req = 1'b0;
    check("clr_done_count", done_cnt, 1);
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    for (int w = 0; w < 8; w++) obi_xfer(0, w * 4, 0, 4'hF, model[w]);

    // reset in the third clear cycle aborts the clear
    for (int w = 0; w < 8; w++) obi_xfer(1, w * 4, 32'hFFFF_FFFF, 4'hF, 0);
    obi_xfer(0, 32'h04, 0, 4'hF, 32'hFFFF_FFFF);
    done_cnt = 0;
    clear = 1'b1;
    @(posedge CLK); #1;
    clear = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_busy", clear_busy, 0);
    check("abort_done", clear_done, 0);
    check("abort_rvalid", rsp.rvalid, 0);
    check("abort_fvalid", filter_valid, 0);
    check("abort_rdata", rsp.rdata, 0);
    check("abort_frdata", filter_rdata, 0);
    @(posedge CLK); #1;
    idle_cycles(2);
    check("abort_done_count", done_cnt, 0);
    for (int w = 0; w < 8; w++) obi_xfer(0, w * 4, 0, 4'hF, w < 3 ? 32'h0 : 32'hFFFF_FFFF);
    idle_cycles(3);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
